// File: rtl/multi_ch_sync_filter.sv
// Multi-channel level synchroniser with stability filter and edge pulses.
// Each bit is an independent level; not for multi-bit buses.
module multi_ch_sync_filter #(
    parameter int                NUM_CH        = 4,
    parameter int                SYNC_STAGES   = 2,
    parameter int                FILTER_CYCLES = 4,
    parameter logic [NUM_CH-1:0] RST_VAL       = '0
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] async_i,
    output logic [NUM_CH-1:0] sync_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic              change_o
);

    localparam int            CW      = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

    // Pure flop chain: nothing may sit between stages.
    (* ASYNC_REG = "TRUE" *)
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] stage_q;

    logic [NUM_CH-1:0]         sq;
    logic [NUM_CH-1:0]         filt_q, filt_d;
    logic [NUM_CH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]         rise_q, fall_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sq = stage_q[SYNC_STAGES-1];

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sq[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                filt_d[i] = sq[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= RST_VAL;
            cnt_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            rise_q <= filt_d & ~filt_q;
            fall_q <= ~filt_d & filt_q;
        end
    end

    assign sync_o   = filt_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign change_o = |(rise_q | fall_q);

endmodule

// File: tb/tb_multi_ch_sync_filter.sv
// Bench for multi_ch_sync_filter: directed tables and sequences,
// then random levels checked against a run-length reference model.
module tb_multi_ch_sync_filter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a_in;

    always #5 clk = ~clk;

    logic [3:0] sa, ra, fa, sb, rb, fb;
    logic       ca, cb;
    logic [0:0] sc, rc, fc;
    logic       cc;

    multi_ch_sync_filter #(
        .NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(4), .RST_VAL(4'b0101)
    ) u_a (
        .clk_i(clk), .rst_n(rst_n), .async_i(a_in),
        .sync_o(sa), .rise_o(ra), .fall_o(fa), .change_o(ca)
    );

    multi_ch_sync_filter #(
        .NUM_CH(4), .SYNC_STAGES(2), .FILTER_CYCLES(4), .RST_VAL(4'b0000)
    ) u_b (
        .clk_i(clk), .rst_n(rst_n), .async_i(a_in),
        .sync_o(sb), .rise_o(rb), .fall_o(fb), .change_o(cb)
    );

    multi_ch_sync_filter #(
        .NUM_CH(1), .SYNC_STAGES(3), .FILTER_CYCLES(1), .RST_VAL(1'b0)
    ) u_c (
        .clk_i(clk), .rst_n(rst_n), .async_i(a_in[0:0]),
        .sync_o(sc), .rise_o(rc), .fall_o(fc), .change_o(cc)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Reference model: a level is accepted once the synchronised input has
    // differed from the current output on FILTER_CYCLES consecutive edges
    // since the previous acceptance. Models: 0=u_a, 1=u_b, 2=u_c.
    logic [3:0] samp[$];
    int         S_m[3]  = '{2, 2, 3};
    int         F_m[3]  = '{4, 4, 1};
    int         NC[3]   = '{4, 4, 1};
    logic [3:0] RV_m[3] = '{4'b0101, 4'b0000, 4'b0000};
    logic [3:0] mf[3], mr[3], mff[3];
    int         la[3][4];

    function automatic logic [3:0] sqv(input int m, input int j);
        if (j >= S_m[m]) return samp[j - S_m[m]];
        return RV_m[m];
    endfunction

    task automatic model_reset();
        samp.delete();
        for (int m = 0; m < 3; m++) begin
            mf[m]  = RV_m[m];
            mr[m]  = '0;
            mff[m] = '0;
            for (int c = 0; c < 4; c++) la[m][c] = -1;
        end
    endtask

    task automatic model_edge(input logic [3:0] v);
        int         n;
        logic       ok;
        logic [3:0] s;
        samp.push_back(v);
        n = samp.size() - 1;
        for (int m = 0; m < 3; m++) begin
            mr[m]  = '0;
            mff[m] = '0;
            for (int c = 0; c < NC[m]; c++) begin
                ok = 1'b1;
                for (int k = 0; k < F_m[m]; k++) begin
                    if (n - k <= la[m][c]) begin
                        ok = 1'b0;
                    end else begin
                        s = sqv(m, n - k);
                        if (s[c] == mf[m][c]) ok = 1'b0;
                    end
                end
                if (ok) begin
                    if (mf[m][c]) mff[m][c] = 1'b1;
                    else          mr[m][c]  = 1'b1;
                    mf[m][c] = ~mf[m][c];
                    la[m][c] = n;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_a"}, {sa, ra, fa, ca},
            {mf[0], mr[0], mff[0], |(mr[0] | mff[0])});
        chk({tag, "_b"}, {sb, rb, fb, cb},
            {mf[1], mr[1], mff[1], |(mr[1] | mff[1])});
        chk({tag, "_c"}, {sc, rc, fc, cc},
            {mf[2][0], mr[2][0], mff[2][0], mr[2][0] | mff[2][0]});
    endtask

    // Drive at a negedge, clock once, land on the next negedge.
    task automatic tick(input logic [3:0] v);
        a_in = v;
        @(posedge clk);
        model_edge(v);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] v, input int cyc);
        a_in  = v;
        rst_n = 1'b0;
        model_reset();
        repeat (cyc) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] s, r, f;
        logic       ch;
        logic       sc, rc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int rep, input logic [3:0] a, input logic [3:0] s,
                       input logic [3:0] r, input logic [3:0] f,
                       input logic c_s, input logic c_r);
        vec_t v;
        v.a  = a;  v.s  = s; v.r = r; v.f = f;
        v.ch = |(r | f);
        v.sc = c_s; v.rc = c_r;
        for (int i = 0; i < rep; i++) tbl.push_back(v);
    endtask

    initial begin
        int         nr, nf, pos;
        logic [3:0] cur;

        // ch0 step, ch1 3-cycle glitch, ch1 4-cycle pulse (u_b and u_c)
        add(3, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        add(1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
        add(1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        add(1, 4'h1, 4'h1, 4'h1, 4'h0, 1'b1, 1'b0);
        add(1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0);
        add(3, 4'h3, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0);
        add(4, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0);
        add(4, 4'h3, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0);
        add(1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0);
        add(1, 4'h1, 4'h3, 4'h2, 4'h0, 1'b1, 1'b0);
        add(3, 4'h1, 4'h3, 4'h0, 4'h0, 1'b1, 1'b0);
        add(1, 4'h1, 4'h1, 4'h0, 4'h2, 1'b1, 1'b0);
        add(1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0);

        rst_n = 1'b0;
        a_in  = '0;
        model_reset();
        @(negedge clk);

        // T1: reset value held, then ch1/ch3 rise together
        a_in = 4'hF;
        repeat (3) @(negedge clk);
        chk("t1_in_reset", {sa, ra, fa, ca}, {4'b0101, 4'h0, 4'h0, 1'b0});
        rst_n = 1'b1;
        for (int e = 0; e < 7; e++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("t1_e%0d", e), {sa, ra, fa, ca},
                {(e >= 5) ? 4'hF : 4'b0101, (e == 5) ? 4'b1010 : 4'h0,
                 4'h0, e == 5});
        end

        // T2/T3/T6 step: vector table
        do_reset(4'h0, 2);
        repeat (3) tick(4'h0);
        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].a);
            chk($sformatf("tbl_%0d", i), {sb, rb, fb, cb, sc, rc},
                {tbl[i].s, tbl[i].r, tbl[i].f, tbl[i].ch,
                 tbl[i].sc, tbl[i].rc});
        end

        // T4: chatter on ch2, then hold high
        do_reset(4'h0, 2);
        repeat (3) tick(4'h0);
        nr  = 0;
        nf  = 0;
        pos = -1;
        for (int k = 0; k < 40; k++) begin
            tick((k >= 20 || k % 2 == 0) ? 4'h4 : 4'h0);
            if (rb[2]) begin nr++; pos = k; end
            if (fb[2]) nf++;
        end
        chk("t4_rises", nr, 1);
        chk("t4_falls", nf, 0);
        chk("t4_rise_pos", pos, 25);
        chk("t4_level", sb[2], 1'b1);

        // T5: simultaneous rise, then reset while counting the fall
        do_reset(4'h0, 2);
        repeat (3) tick(4'h0);
        for (int k = 0; k < 7; k++) begin
            tick(4'hF);
            if (k == 5) chk("t5_rise_all", {rb, cb}, {4'hF, 1'b1});
            if (k == 6) chk("t5_chg_one", {rb, cb}, {4'h0, 1'b0});
        end
        for (int k = 0; k < 4; k++) tick(4'h0);
        chk("t5_pre_rst", {sb, fb}, {4'hF, 4'h0});
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_rst_b", {sb, fb, cb}, {4'h0, 4'h0, 1'b0});
        chk("t5_rst_a", {sa, fa, ca}, {4'b0101, 4'h0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        // Random levels against the model, with one mid-run reset
        do_reset(4'h0, 2);
        cur = '0;
        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < 4; c++)
                if ($urandom_range(5) == 0) cur[c] = ~cur[c];
            tick(cur);
            check_model($sformatf("rnd%0d", k));
            if (k == 300) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check_model("rnd_rst");
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
